// File: rtl/fw_mem_pkg.sv
// Shared widths and load-FSM state encoding for the firmware-load memory.
package fw_mem_pkg;

   localparam int REG_WIDTH     = 8;
   localparam int FW_ADDR_WIDTH = 16;
   localparam int FW_DATA_WIDTH = REG_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } ld_state_e;

endpackage

// File: rtl/fw_mem_array.sv
// Single-write-port storage with a registered read port; out-of-range
// addresses read as zero and never write.
module fw_mem_array #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 2**ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int                  IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  wr_in_range, rd_in_range;

   assign wr_in_range = ({1'b0, waddr_i} < LIMIT);
   assign rd_in_range = ({1'b0, raddr_i} < LIMIT);

   // Contents survive reset on purpose: a reset mid-load keeps written words.
   always_ff @(posedge clk_i) begin
      if (we_i && wr_in_range) begin
         mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
      end
   end

   always_comb begin
      rdata_d = '0;
      if (rd_in_range) begin
         rdata_d = mem_q[raddr_i[IDX_W-1:0]];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fw_mem.sv
// Firmware-load memory: a CPU read/write port plus a streaming loader that
// stalls the CPU while it fills memory from ld_base upward.
module fw_mem
   import fw_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = FW_ADDR_WIDTH,
   parameter int DATA_WIDTH = FW_DATA_WIDTH,
   parameter int DEPTH      = 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   input  logic                  ld_start,
   input  logic [ADDR_WIDTH-1:0] ld_base,
   input  logic                  ld_valid,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  ld_last,
   output logic                  ld_ready,
   output logic                  cpu_hold,
   output logic                  ld_done,
   output logic [ADDR_WIDTH:0]   ld_count,
   output logic [DATA_WIDTH-1:0] ld_sum,
   output logic                  wrap_err
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);

   ld_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] sum_q, sum_d;
   logic                  wrap_q, wrap_d;

   logic                  beat_acc;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   assign beat_acc = (state_q == ST_LOAD) && ld_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         wrap_q  <= wrap_d;
      end
   end

   // ld_start is only honoured from IDLE; a restart mid-load is dropped.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      wrap_d  = wrap_q;
      case (state_q)
         ST_IDLE: begin
            if (ld_start) begin
               state_d = ST_LOAD;
               ptr_d   = ld_base;
               cnt_d   = '0;
               sum_d   = '0;
               wrap_d  = 1'b0;
            end
         end
         ST_LOAD: begin
            if (beat_acc) begin
               cnt_d = cnt_q + CNT_ONE;
               sum_d = sum_q + ld_data;
               if (ptr_q == LAST_ADDR) begin
                  ptr_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  ptr_d = ptr_q + PTR_ONE;
               end
               if (ld_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign ld_ready = (state_q == ST_LOAD);
   assign cpu_hold = (state_q != ST_IDLE);
   assign ld_done  = (state_q == ST_DONE);
   assign ld_count = cnt_q;
   assign ld_sum   = sum_q;
   assign wrap_err = wrap_q;

   // Loader owns the write port; CPU writes only land while not held.
   assign mem_we    = beat_acc || (we && !cpu_hold);
   assign mem_waddr = beat_acc ? ptr_q   : addr;
   assign mem_wdata = beat_acc ? ld_data : din;

   fw_mem_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .raddr_i (addr),
      .rdata_o (dout)
   );

endmodule

// File: tb/tb_fw_mem.sv
// Bench for fw_mem: vector table, directed corner sequences and a random
// run against a behavioural model of the load protocol and memory.
module tb_fw_mem;

   localparam int MDEPTH = 65536;
   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_DONE = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        we, ld_start, ld_valid, ld_last;
   logic [15:0] addr, ld_base;
   logic [7:0]  din, ld_data, dout, ld_sum;
   logic        ld_ready, cpu_hold, ld_done, wrap_err;
   logic [16:0] ld_count;

   logic        b_we, b_ld_start, b_ld_valid, b_ld_last;
   logic [15:0] b_addr, b_ld_base;
   logic [7:0]  b_din, b_ld_data, b_dout, b_ld_sum;
   logic        b_ld_ready, b_cpu_hold, b_ld_done, b_wrap_err;
   logic [16:0] b_ld_count;

   fw_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .we(we), .addr(addr), .din(din), .dout(dout),
      .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_last(ld_last), .ld_ready(ld_ready), .cpu_hold(cpu_hold), .ld_done(ld_done),
      .ld_count(ld_count), .ld_sum(ld_sum), .wrap_err(wrap_err));

   fw_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(16)) dut_b (
      .clk(clk), .reset_n(reset_n), .we(b_we), .addr(b_addr), .din(b_din), .dout(b_dout),
      .ld_start(b_ld_start), .ld_base(b_ld_base), .ld_valid(b_ld_valid), .ld_data(b_ld_data),
      .ld_last(b_ld_last), .ld_ready(b_ld_ready), .cpu_hold(b_cpu_hold), .ld_done(b_ld_done),
      .ld_count(b_ld_count), .ld_sum(b_ld_sum), .wrap_err(b_wrap_err));

   int n_checks = 0;
   int n_err    = 0;

   // behavioural model of the full-depth instance
   int          m_st, m_ptr, m_cnt, m_sum;
   bit          m_wrap, m_dk;
   logic [7:0]  m_dout;
   logic [7:0]  mm [int];

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  din;
      logic        st;
      logic [15:0] base;
      logic        vld;
      logic [7:0]  data;
      logic        last;
      logic        e_rdy, e_hold, e_done;
      int          e_cnt;
      logic [7:0]  e_sum;
      logic        chk_d;
      logic [7:0]  e_dout;
   } vec_t;

   vec_t tv [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_idle();
      we = 0; addr = '0; din = '0; ld_start = 0; ld_base = '0;
      ld_valid = 0; ld_data = '0; ld_last = 0;
   endtask

   task automatic set_idle_b();
      b_we = 0; b_addr = '0; b_din = '0; b_ld_start = 0; b_ld_base = '0;
      b_ld_valid = 0; b_ld_data = '0; b_ld_last = 0;
   endtask

   // One clock: predict from the inputs now applied, step, compare.
   task automatic cycle();
      int nst, nptr, ncnt, nsum;
      bit nwrap, acc;
      nst = m_st; nptr = m_ptr; ncnt = m_cnt; nsum = m_sum; nwrap = m_wrap;
      acc = (m_st == M_LOAD) && (ld_valid === 1'b1);
      if (mm.exists(int'(addr))) begin
         m_dout = mm[int'(addr)];
         m_dk   = 1;
      end else begin
         m_dk = 0;
      end
      if (acc) mm[m_ptr] = ld_data;
      else if (we && m_st == M_IDLE) mm[int'(addr)] = din;
      if (m_st == M_IDLE) begin
         if (ld_start) begin
            nst = M_LOAD; nptr = int'(ld_base); ncnt = 0; nsum = 0; nwrap = 0;
         end
      end else if (m_st == M_LOAD) begin
         if (acc) begin
            ncnt = m_cnt + 1;
            nsum = (m_sum + int'(ld_data)) % 256;
            if (m_ptr == MDEPTH - 1) begin
               nptr = 0; nwrap = 1;
            end else begin
               nptr = m_ptr + 1;
            end
            if (ld_last) nst = M_DONE;
         end
      end else begin
         nst = M_IDLE;
      end
      @(posedge clk);
      #1;
      m_st = nst; m_ptr = nptr; m_cnt = ncnt; m_sum = nsum; m_wrap = nwrap;
      chk("ld_ready", ld_ready, m_st == M_LOAD);
      chk("cpu_hold", cpu_hold, m_st != M_IDLE);
      chk("ld_done", ld_done, m_st == M_DONE);
      chk("ld_count", ld_count, m_cnt);
      chk("ld_sum", ld_sum, m_sum);
      chk("wrap_err", wrap_err, m_wrap);
      if (m_dk) chk("dout", dout, m_dout);
   endtask

   task automatic do_reset();
      reset_n = 0;
      set_idle();
      set_idle_b();
      #1;
      m_st = M_IDLE; m_ptr = 0; m_cnt = 0; m_sum = 0; m_wrap = 0;
      m_dout = '0; m_dk = 1;
      chk("rst_dout", dout, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_cpu_hold", cpu_hold, 0);
      chk("rst_ld_done", ld_done, 0);
      chk("rst_ld_count", ld_count, 0);
      chk("rst_ld_sum", ld_sum, 0);
      chk("rst_wrap_err", wrap_err, 0);
      chk("rst_b_dout", b_dout, 0);
      chk("rst_b_hold", b_cpu_hold, 0);
      chk("rst_b_wrap", b_wrap_err, 0);
      @(posedge clk);
      #1;
      reset_n = 1;
   endtask

   task automatic beat(input logic [7:0] d, input logic l);
      ld_valid = 1; ld_data = d; ld_last = l;
      cycle();
      ld_valid = 0; ld_last = 0;
   endtask

   task automatic read_a(input logic [15:0] a, input logic [7:0] exp, input string nm);
      addr = a;
      cycle();
      chk(nm, dout, exp);
   endtask

   function automatic logic [15:0] pick_addr();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return 16'(16'hFFFC + $urandom_range(0, 3));
      if (r == 1) return 16'($urandom_range(0, 2));
      return 16'(16'h0F00 + $urandom_range(0, 63));
   endfunction

   initial begin
      reset_n = 1;
      set_idle();
      set_idle_b();
      m_st = M_IDLE; m_ptr = 0; m_cnt = 0; m_sum = 0; m_wrap = 0; m_dk = 0; m_dout = '0;
      #1;
      do_reset();

      // we,addr,din,st,base,vld,data,last | rdy,hold,done,cnt,sum,chk_d,dout
      tv.push_back('{0, 16'h0000, 0, 1, 16'h0200, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0, 8'h00});
      tv.push_back('{0, 16'h0000, 0, 0, 16'h0000, 1, 8'h11, 0, 1, 1, 0, 1, 8'h11, 0, 8'h00});
      tv.push_back('{0, 16'h0000, 0, 0, 16'h0000, 1, 8'h22, 0, 1, 1, 0, 2, 8'h33, 0, 8'h00});
      tv.push_back('{0, 16'h0000, 0, 0, 16'h0000, 1, 8'h33, 1, 0, 1, 1, 3, 8'h66, 0, 8'h00});
      tv.push_back('{0, 16'h0200, 0, 0, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 3, 8'h66, 1, 8'h11});
      tv.push_back('{0, 16'h0201, 0, 0, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 3, 8'h66, 1, 8'h22});
      tv.push_back('{0, 16'h0202, 0, 0, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 3, 8'h66, 1, 8'h33});
      tv.push_back('{0, 16'h0000, 0, 1, 16'h0240, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0, 8'h00});
      tv.push_back('{0, 16'h0000, 0, 0, 16'h0000, 1, 8'h5C, 1, 0, 1, 1, 1, 8'h5C, 0, 8'h00});
      tv.push_back('{0, 16'h0240, 0, 0, 16'h0000, 1, 8'h77, 1, 0, 0, 0, 1, 8'h5C, 1, 8'h5C});
      for (int i = 0; i < tv.size(); i++) begin
         we = tv[i].we; addr = tv[i].addr; din = tv[i].din; ld_start = tv[i].st;
         ld_base = tv[i].base; ld_valid = tv[i].vld; ld_data = tv[i].data; ld_last = tv[i].last;
         cycle();
         chk("tv_ready", ld_ready, tv[i].e_rdy);
         chk("tv_hold", cpu_hold, tv[i].e_hold);
         chk("tv_done", ld_done, tv[i].e_done);
         chk("tv_count", ld_count, tv[i].e_cnt);
         chk("tv_sum", ld_sum, tv[i].e_sum);
         if (tv[i].chk_d) chk("tv_dout", dout, tv[i].e_dout);
      end
      set_idle();

      // CPU write discarded while held, accepted once back in IDLE
      we = 1; addr = 16'h0010; din = 8'h5A; cycle(); we = 0;
      ld_start = 1; ld_base = 16'h0400; cycle(); ld_start = 0;
      we = 1; addr = 16'h0010; din = 8'hAA; cycle(); we = 0;
      beat(8'h01, 1);
      cycle();
      read_a(16'h0010, 8'h5A, "hold_wr_discard");
      we = 1; din = 8'hAA; addr = 16'h0010; cycle(); we = 0;
      chk("rdw_old_data", dout, 8'h5A);
      cycle();
      chk("cpu_wr_after_load", dout, 8'hAA);

      // reset after two of five beats
      ld_start = 1; ld_base = 16'h0500; cycle(); ld_start = 0;
      beat(8'hA1, 0);
      beat(8'hA2, 0);
      ld_valid = 1; ld_data = 8'hA3;
      #2;
      do_reset();
      read_a(16'h0500, 8'hA1, "rst_keep_w0");
      read_a(16'h0501, 8'hA2, "rst_keep_w1");
      addr = '0;
      ld_start = 1; ld_base = 16'h0600; cycle(); ld_start = 0;
      chk("fresh_ready", ld_ready, 1);
      chk("fresh_count", ld_count, 0);
      beat(8'h07, 1);
      chk("fresh_sum", ld_sum, 8'h07);
      cycle();

      // valid toggling with a sum that wraps to zero
      ld_start = 1; ld_base = 16'h0700; cycle(); ld_start = 0;
      beat(8'hFF, 0);
      ld_data = 8'h55; cycle();
      beat(8'h01, 1);
      cycle();
      chk("toggle_count", ld_count, 2);
      chk("toggle_sum", ld_sum, 8'h00);

      // restart ignored mid-load
      ld_start = 1; ld_base = 16'h0800; cycle(); ld_start = 0;
      beat(8'h10, 0);
      ld_start = 1; ld_base = 16'h0300; beat(8'h20, 0); ld_start = 0;
      chk("restart_count", ld_count, 2);
      beat(8'h30, 1);
      cycle();
      read_a(16'h0801, 8'h20, "restart_ptr1");
      read_a(16'h0802, 8'h30, "restart_ptr2");

      // 16-deep instance: pointer wrap and out-of-range accesses
      set_idle();
      b_ld_start = 1; b_ld_base = 16'h000E; cycle(); b_ld_start = 0;
      chk("b_ready", b_ld_ready, 1);
      for (int k = 1; k <= 4; k++) begin
         b_ld_valid = 1; b_ld_data = 8'(k); b_ld_last = (k == 4);
         cycle();
         chk("b_wrap_step", b_wrap_err, k >= 2);
      end
      b_ld_valid = 0; b_ld_last = 0;
      chk("b_done", b_ld_done, 1);
      chk("b_hold", b_cpu_hold, 1);
      cycle();
      chk("b_count", b_ld_count, 4);
      chk("b_sum", b_ld_sum, 8'h0A);
      chk("b_wrap_sticky", b_wrap_err, 1);
      for (int k = 0; k < 4; k++) begin
         b_addr = 16'((14 + k) % 16);
         cycle();
         chk("b_wrap_data", b_dout, k + 1);
      end
      b_we = 1; b_addr = 16'h0020; b_din = 8'h99; cycle(); b_we = 0;
      cycle();
      chk("b_oor_read", b_dout, 0);
      b_addr = 16'h001E; cycle();
      chk("b_oor_alias", b_dout, 0);
      b_addr = 16'h000E; cycle();
      chk("b_inrange_intact", b_dout, 1);
      set_idle_b();

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         ld_start = ($urandom_range(0, 15) == 0);
         ld_base  = pick_addr();
         ld_valid = 1'($urandom_range(0, 1));
         ld_data  = 8'($urandom);
         ld_last  = ($urandom_range(0, 5) == 0);
         we       = 1'($urandom_range(0, 1));
         addr     = pick_addr();
         din      = 8'($urandom);
         if (i % 700 == 350) begin
            #2;
            do_reset();
         end else begin
            cycle();
         end
      end
      set_idle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
